// File: rtl/gps_feed_rx_pkg.sv
// gps_feed_rx_pkg: feed-port bit map and channel front-end state encodings.
package gps_feed_rx_pkg;
    localparam int FEED_DATA_MSB     = 2;
    localparam int FEED_DATA_LSB     = 0;
    localparam int FEED_CLK_BIT      = 3;
    localparam int FEED_COMPLETE_BIT = 6;
    localparam int FEED_RESET_BIT    = 7;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/gps_feed_rx_if.sv
// gps_feed_rx_if: valid/ready sample stream from the feed front end to the channel core.
interface gps_feed_rx_if #(parameter int DATA_WIDTH = 3) ();
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    modport master(output valid, output data, input ready);
    modport slave(input valid, input data, output ready);
endinterface

// File: rtl/gps_feed_rx_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush; a push into a full FIFO only lands
// when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = r_wr == r_rd;
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
    assign o_level = r_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            r_wr    <= r_wr + (AW+1)'(w_push);
            r_rd    <= r_rd + (AW+1)'(w_pop);
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
endmodule

// File: rtl/gps_feed_rx.sv
// gps_feed_rx: synchronises the software feed port, detects sample-clock rises and
// buffers IF samples into a valid/ready stream with feed reset/complete status.
module gps_feed_rx
    import gps_feed_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int DATA_WIDTH  = 3,
    parameter int COUNT_WIDTH = 16,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             gps_data_in,
    gps_feed_rx_if.master          smp,
    output logic                   feed_reset_out,
    output logic                   feed_complete_out,
    output logic [COUNT_WIDTH-1:0] sample_count,
    output logic                   overflow,
    output logic [LW-1:0]          fifo_level
);
    logic [7:0]            r_sync [SYNC_STAGES];
    logic                  r_prev_clk;
    logic                  r_edge;
    logic [DATA_WIDTH-1:0] r_data;
    state_e                r_state;
    state_e                w_next;
    logic [7:0]            w_s;
    logic                  w_edge;
    logic                  w_rst;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_unused;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_unused = ^w_s[5:4];
    assign w_rst    = w_s[FEED_RESET_BIT];
    assign w_edge   = w_s[FEED_CLK_BIT] & ~r_prev_clk;
    assign w_push   = r_edge & (r_state == RUN) & ~w_rst;
    assign w_pop    = smp.valid & smp.ready;
    assign smp.valid = ~w_empty;
    assign feed_complete_out = r_state == DONE;

    // Edges are qualified and latched one cycle before the push to pipeline data capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync         <= '{default: '0};
            r_prev_clk     <= 1'b0;
            r_edge         <= 1'b0;
            r_data         <= '0;
            r_state        <= IDLE;
            feed_reset_out <= 1'b0;
            sample_count   <= '0;
            overflow       <= 1'b0;
        end else begin
            r_sync[0] <= gps_data_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev_clk     <= w_s[FEED_CLK_BIT];
            r_edge         <= w_edge & (r_state == RUN) & ~w_rst;
            r_data         <= DATA_WIDTH'(w_s[FEED_DATA_MSB:FEED_DATA_LSB]);
            r_state        <= w_next;
            feed_reset_out <= w_rst;
            sample_count   <= w_rst ? '0 : sample_count + COUNT_WIDTH'(w_push);
            overflow       <= w_rst ? 1'b0 : overflow | (w_push & w_full & ~w_pop);
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_rst) w_next = IDLE;
        else if (r_state == IDLE) w_next = RUN;
        else if (r_state == RUN && w_s[FEED_COMPLETE_BIT] && w_empty && !w_push && !w_edge) w_next = DONE;
    end

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (w_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_data),
        .o_data  (smp.data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );
endmodule

// File: tb/tb_gps_feed_rx.sv
// tb_gps_feed_rx: directed scenario bench for the GPS feed receive front end.
module tb_gps_feed_rx;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  gps_data_in;
    logic        feed_reset_out;
    logic        feed_complete_out;
    logic [15:0] sample_count;
    logic        overflow;
    logic [3:0]  fifo_level;
    int          checks = 0;
    int          errors = 0;

    gps_feed_rx_if #(.DATA_WIDTH(3)) smp ();

    gps_feed_rx dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .gps_data_in       (gps_data_in),
        .smp               (smp),
        .feed_reset_out    (feed_reset_out),
        .feed_complete_out (feed_complete_out),
        .sample_count      (sample_count),
        .overflow          (overflow),
        .fifo_level        (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [2:0] d);
        gps_data_in[2:0] = d;
        cyc(3);
        gps_data_in[3] = 1'b1;
        cyc(4);
        gps_data_in[3] = 1'b0;
        cyc(4);
    endtask

    task automatic feed_rst();
        gps_data_in[7] = 1'b1;
        cyc(4);
        gps_data_in[7] = 1'b0;
        cyc(4);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        gps_data_in = 8'h00;
        smp.ready = 1'b0;
        cyc(2);
        checks++;
        if ({smp.valid, smp.data, feed_reset_out, feed_complete_out, sample_count, overflow, fifo_level} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b d=%0d fr=%0b fc=%0b cnt=%0d ov=%0b lvl=%0d exp all 0",
                     smp.valid, smp.data, feed_reset_out, feed_complete_out, sample_count, overflow, fifo_level);
        end
        reset_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_single();
        logic [3:0] seen = '0;
        gps_data_in[2:0] = 3'b101;
        cyc(4);
        gps_data_in[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            seen[i] = smp.valid;
        end
        checks++;
        if (seen !== 4'b1000) begin
            errors++;
            $display("FAIL single_latency got valid history=%b exp=1000", seen);
        end
        checks++;
        if (smp.data !== 3'd5 || sample_count !== 16'd1) begin
            errors++;
            $display("FAIL single_data got data=%0d cnt=%0d exp data=5 cnt=1", smp.data, sample_count);
        end
        smp.ready = 1'b1;
        cyc(1);
        smp.ready = 1'b0;
        checks++;
        if (smp.valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL single_pop got valid=%0b lvl=%0d exp valid=0 lvl=0", smp.valid, fifo_level);
        end
        gps_data_in[3] = 1'b0;
        cyc(4);
    endtask

    task automatic test_overflow();
        feed_rst();
        for (int i = 0; i < 9; i++) pulse(3'(i));
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1 || sample_count !== 16'd9) begin
            errors++;
            $display("FAIL ovf_state got lvl=%0d ov=%0b cnt=%0d exp lvl=8 ov=1 cnt=9", fifo_level, overflow, sample_count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (smp.valid !== 1'b1 || smp.data !== 3'(i)) begin
                errors++;
                $display("FAIL ovf_pop%0d got valid=%0b data=%0d exp valid=1 data=%0d", i, smp.valid, smp.data, i);
            end
            smp.ready = 1'b1;
            cyc(1);
        end
        smp.ready = 1'b0;
        checks++;
        if (smp.valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL ovf_drained got valid=%0b lvl=%0d exp valid=0 lvl=0", smp.valid, fifo_level);
        end
    endtask

    task automatic test_full_push_pop();
        logic [2:0] exp_q [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd6};
        feed_rst();
        for (int i = 1; i <= 8; i++) pulse(3'(i));
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_fill got lvl=%0d ov=%0b exp lvl=8 ov=0", fifo_level, overflow);
        end
        gps_data_in[2:0] = 3'd6;
        cyc(3);
        gps_data_in[3] = 1'b1;
        cyc(3);
        smp.ready = 1'b1;
        cyc(1);
        smp.ready = 1'b0;
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0 || sample_count !== 16'd9) begin
            errors++;
            $display("FAIL fpp_same_cycle got lvl=%0d ov=%0b cnt=%0d exp lvl=8 ov=0 cnt=9", fifo_level, overflow, sample_count);
        end
        gps_data_in[3] = 1'b0;
        cyc(4);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (smp.valid !== 1'b1 || smp.data !== exp_q[i]) begin
                errors++;
                $display("FAIL fpp_pop%0d got valid=%0b data=%0d exp valid=1 data=%0d", i, smp.valid, smp.data, exp_q[i]);
            end
            smp.ready = 1'b1;
            cyc(1);
        end
        smp.ready = 1'b0;
    endtask

    task automatic test_flush();
        feed_rst();
        for (int i = 0; i < 9; i++) pulse(3'(i));
        smp.ready = 1'b1;
        cyc(3);
        smp.ready = 1'b0;
        checks++;
        if (fifo_level !== 4'd5 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre got lvl=%0d ov=%0b exp lvl=5 ov=1", fifo_level, overflow);
        end
        gps_data_in[7] = 1'b1;
        gps_data_in[3] = 1'b1;
        cyc(4);
        checks++;
        if (smp.valid !== 1'b0 || fifo_level !== 4'd0 || sample_count !== 16'd0 || overflow !== 1'b0 || feed_reset_out !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear got valid=%0b lvl=%0d cnt=%0d ov=%0b fr=%0b exp 0 0 0 0 1",
                     smp.valid, fifo_level, sample_count, overflow, feed_reset_out);
        end
        gps_data_in[3] = 1'b0;
        cyc(3);
        gps_data_in[3] = 1'b1;
        cyc(4);
        checks++;
        if (fifo_level !== 4'd0 || sample_count !== 16'd0) begin
            errors++;
            $display("FAIL flush_edge_ignored got lvl=%0d cnt=%0d exp 0 0", fifo_level, sample_count);
        end
        gps_data_in[3] = 1'b0;
        gps_data_in[7] = 1'b0;
        cyc(4);
        checks++;
        if (feed_reset_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_release got fr=%0b exp 0", feed_reset_out);
        end
        pulse(3'd3);
        checks++;
        if (fifo_level !== 4'd1 || sample_count !== 16'd1 || smp.data !== 3'd3) begin
            errors++;
            $display("FAIL flush_rerun got lvl=%0d cnt=%0d data=%0d exp 1 1 3", fifo_level, sample_count, smp.data);
        end
    endtask

    task automatic test_complete();
        logic [2:0] fc_hist = '0;
        feed_rst();
        for (int i = 1; i <= 3; i++) pulse(3'(i));
        gps_data_in[6] = 1'b1;
        cyc(4);
        checks++;
        if (feed_complete_out !== 1'b0 || fifo_level !== 4'd3) begin
            errors++;
            $display("FAIL done_wait got fc=%0b lvl=%0d exp fc=0 lvl=3", feed_complete_out, fifo_level);
        end
        smp.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            fc_hist[i] = feed_complete_out;
        end
        smp.ready = 1'b0;
        checks++;
        if (fc_hist !== 3'b000 || smp.valid !== 1'b0) begin
            errors++;
            $display("FAIL done_drain got fc history=%b valid=%0b exp 000 0", fc_hist, smp.valid);
        end
        cyc(1);
        checks++;
        if (feed_complete_out !== 1'b1) begin
            errors++;
            $display("FAIL done_enter got fc=%0b exp 1", feed_complete_out);
        end
        pulse(3'd5);
        checks++;
        if (sample_count !== 16'd3 || smp.valid !== 1'b0 || feed_complete_out !== 1'b1) begin
            errors++;
            $display("FAIL done_frozen got cnt=%0d valid=%0b fc=%0b exp 3 0 1", sample_count, smp.valid, feed_complete_out);
        end
    endtask

    task automatic test_async_reset();
        gps_data_in[6] = 1'b0;
        feed_rst();
        for (int i = 1; i <= 3; i++) pulse(3'(i));
        checks++;
        if (fifo_level !== 4'd3 || sample_count !== 16'd3) begin
            errors++;
            $display("FAIL areset_pre got lvl=%0d cnt=%0d exp 3 3", fifo_level, sample_count);
        end
        gps_data_in[3] = 1'b1;
        cyc(2);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({smp.valid, smp.data, feed_reset_out, feed_complete_out, sample_count, overflow, fifo_level} !== '0) begin
            errors++;
            $display("FAIL areset_immediate got v=%0b d=%0d fr=%0b fc=%0b cnt=%0d ov=%0b lvl=%0d exp all 0",
                     smp.valid, smp.data, feed_reset_out, feed_complete_out, sample_count, overflow, fifo_level);
        end
        gps_data_in = 8'h00;
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        pulse(3'd4);
        checks++;
        if (fifo_level !== 4'd1 || sample_count !== 16'd1 || smp.data !== 3'd4) begin
            errors++;
            $display("FAIL areset_rerun got lvl=%0d cnt=%0d data=%0d exp 1 1 4", fifo_level, sample_count, smp.data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_complete();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gps_feed_rx.md
Name: gps_feed_rx

Overview:
Receive front end for the tracking channel. It takes the 8-bit software-driven sample port written by the data-feed processor, which is asynchronous to the channel clock. It synchronises the port, detects sample-clock rising edges, and buffers 3-bit IF samples in a small FIFO. It presents the samples to the channel core as a valid/ready stream, together with clean feed_reset / feed_complete status.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchroniser (must be ≥2).
FIFO_DEPTH, 8, sample buffer entries (power of 2, ≥2).
DATA_WIDTH, 3, IF sample width.
COUNT_WIDTH, 16, width of the accepted-edge counter.

Ports:
clk  in  1  channel clock, 200 MHz domain.
reset_n  in  1  asynchronous, active-low reset.
gps_data_in  in  8  asynchronous feed port. Bits [2:0] sample, [3] sample clock, [6] feed_complete, [7] feed_reset; bits [5:4] unused.
sample_ready  in  1  consumer accepts head sample this cycle.
sample_valid  out  1  FIFO non-empty.
sample_data  out  DATA_WIDTH  FIFO head.
feed_reset_out  out  1  synchronised feed_reset.
feed_complete_out  out  1  high in DONE state.
sample_count  out  COUNT_WIDTH  rising edges detected in RUN.
overflow  out  1  sticky; a sample was dropped because the FIFO was full.
fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset_n low, async): all outputs are 0, FIFO is empty, state is IDLE, synchroniser and edge history are cleared.
- Synchroniser: all 8 input bits pass through SYNC_STAGES flops, giving s. prev_clk is a register of s[3]. edge = s[3] & ~prev_clk.
- Data contract: software holds bits [2:0] stable from at least 2 clk periods before the bit-3 rise until the fall. Data is taken from s[2:0] in the edge cycle.
- State machine IDLE / RUN / DONE:
  - Any state, s[7]=1: next state IDLE. FIFO is flushed, sample_count and overflow clear at the next edge, and an edge in the same cycle is dropped.
  - IDLE, s[7]=0: next state RUN.
  - RUN, edge: push. sample_count increments, wrapping modulo 2^COUNT_WIDTH, and counts dropped samples too.
  - RUN, s[6]=1 and FIFO empty and no push this cycle: next state DONE.
  - DONE: edges are ignored and the count is frozen. feed_complete_out=1. Only s[7] leaves DONE.
- feed_reset_out = s[7], registered.
- FIFO: pop when sample_valid & sample_ready. No bypass: a push into an empty FIFO makes sample_valid rise the following cycle.
- Latency: an input rise captured at clk edge k gives sample_valid high after edge k+SYNC_STAGES+1.
- Full and push with no pop: the sample is dropped, overflow is set, and the FIFO is unchanged.
- Full and push with pop in the same cycle: both succeed and the level stays at FIFO_DEPTH.
- Empty and pop: not possible, because ready is ignored while valid is low.
- fifo_level updates registered and equals the number of entries.
- Pointers are log2(FIFO_DEPTH)+1 bits wide. The MSB distinguishes full from empty.

Decomposition:
- Shared header holds:
  - FEED_DATA_RANGE 2:0
  - FEED_CLK_BIT 3
  - FEED_COMPLETE_BIT 6
  - FEED_RESET_BIT 7
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
- One sub-module, sync_fifo, which is parameterised by width and depth, has a synchronous flush, and exposes full/empty/level.
- The synchroniser, edge detect, state machine and counter stay in gps_feed_rx.

Test Plan:
- Single sample: bring to RUN, set data=3'b101, then after 4 cycles raise bit 3. Expect sample_valid high exactly SYNC_STAGES+1 edges after the rise is captured, sample_data=5, and sample_count=1. With ready=1, valid drops the next cycle.
- Overflow: hold ready=0 and drive 9 edges with data 0..8 (mod 8). Expect fifo_level=8 and overflow=1. Popping then returns 0..7 in order, and sample_count=9.
- Full push+pop: with the FIFO full and ready=1, place an edge in the pop cycle. Expect level to stay 8, no overflow, and the new sample to arrive last.
- feed_reset flush: with 5 entries buffered, raise bit 7. Expect sample_valid=0, fifo_level=0, sample_count=0, overflow=0 and feed_reset_out=1. Edges while bit 7 is high are ignored. After bit 7 falls, state returns to RUN.
- Completion drain: with 3 entries queued, set bit 6. feed_complete_out stays 0 until the third pop, then goes to 1 one cycle later. A subsequent edge leaves sample_count unchanged.
- Async reset: assert reset_n=0 mid-burst between clock edges. All outputs go to 0 immediately. After release, state is IDLE and moves to RUN once s[7]=0.
